// File: rtl/rs_bank.sv
// Multi-entry reservation station: WAYS-wide dispatch, CDB wakeup and lowest-index-first issue.
// Optional RS_DISPATCH_BYPASS_EN: dispatch-time tag compare against the same-cycle CDB.
module rs_bank #(
  parameter int RS_SIZE = 16,
  parameter int WAYS    = 3,
  parameter int PRF     = 64,
  parameter int ROB     = 16,
  parameter int XLEN    = 64,
  parameter int ALU_W   = 5,
  localparam int TW     = $clog2(PRF),
  localparam int RW     = $clog2(ROB),
  localparam int IW     = $clog2(RS_SIZE),
  localparam int FCW    = $clog2(RS_SIZE + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [WAYS-1:0]            cdb_valid,
  input  logic [WAYS-1:0][TW-1:0]    cdb_tag,
  input  logic [WAYS-1:0][XLEN-1:0]  cdb_data,
  input  logic [WAYS-1:0]            disp_valid,
  input  logic [WAYS-1:0][XLEN-1:0]  disp_opa,
  input  logic [WAYS-1:0][XLEN-1:0]  disp_opb,
  input  logic [WAYS-1:0]            disp_opa_valid,
  input  logic [WAYS-1:0]            disp_opb_valid,
  input  logic [WAYS-1:0][TW-1:0]    disp_dest_prf,
  input  logic [WAYS-1:0][RW-1:0]    disp_rob_idx,
  input  logic [WAYS-1:0][31:0]      disp_pc,
  input  logic [WAYS-1:0][15:0]      disp_offset,
  input  logic [WAYS-1:0][ALU_W-1:0] disp_op,
  input  logic [WAYS-1:0]            disp_rd_mem,
  input  logic [WAYS-1:0]            disp_wr_mem,
  input  logic [WAYS-1:0]            fu_ready,
  output logic [WAYS-1:0]            issue_valid,
  output logic [WAYS-1:0][XLEN-1:0]  issue_opa,
  output logic [WAYS-1:0][XLEN-1:0]  issue_opb,
  output logic [WAYS-1:0][TW-1:0]    issue_dest_prf,
  output logic [WAYS-1:0][RW-1:0]    issue_rob_idx,
  output logic [WAYS-1:0][31:0]      issue_pc,
  output logic [WAYS-1:0][15:0]      issue_offset,
  output logic [WAYS-1:0][ALU_W-1:0] issue_op,
  output logic [WAYS-1:0]            issue_rd_mem,
  output logic [WAYS-1:0]            issue_wr_mem,
  output logic [FCW-1:0]             free_count
);

  logic [RS_SIZE-1:0] busy_q, busy_d, opa_v_q, opa_v_d, opb_v_q, opb_v_d;
  logic [RS_SIZE-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [XLEN-1:0]    opa_q  [RS_SIZE];
  logic [XLEN-1:0]    opa_d  [RS_SIZE];
  logic [XLEN-1:0]    opb_q  [RS_SIZE];
  logic [XLEN-1:0]    opb_d  [RS_SIZE];
  logic [TW-1:0]      dest_q [RS_SIZE];
  logic [TW-1:0]      dest_d [RS_SIZE];
  logic [RW-1:0]      rob_q  [RS_SIZE];
  logic [RW-1:0]      rob_d  [RS_SIZE];
  logic [31:0]        pc_q   [RS_SIZE];
  logic [31:0]        pc_d   [RS_SIZE];
  logic [15:0]        off_q  [RS_SIZE];
  logic [15:0]        off_d  [RS_SIZE];
  logic [ALU_W-1:0]   op_q   [RS_SIZE];
  logic [ALU_W-1:0]   op_d   [RS_SIZE];
  logic [FCW-1:0]     free_count_q, free_count_d;

  logic [RS_SIZE-1:0]        rdy;
  logic [WAYS-1:0]           iss_v, fr_ok;
  logic [WAYS-1:0][IW-1:0]   iss_idx, fr_idx;

  assign rdy        = busy_q & opa_v_q & opb_v_q;
  assign free_count = free_count_q;

  // Select the first WAYS ready entries (issue) and first WAYS free entries (allocation).
  always_comb begin
    int n_r;
    int n_f;
    iss_v = '0; iss_idx = '0; fr_ok = '0; fr_idx = '0;
    n_r = 0; n_f = 0;
    for (int e = 0; e < RS_SIZE; e++) begin
      if (rdy[e]) begin
        for (int k = 0; k < WAYS; k++)
          if (n_r == k) begin iss_v[k] = 1'b1; iss_idx[k] = IW'(e); end
        n_r++;
      end
      if (!busy_q[e]) begin
        for (int k = 0; k < WAYS; k++)
          if (n_f == k) begin fr_ok[k] = 1'b1; fr_idx[k] = IW'(e); end
        n_f++;
      end
    end
  end

  always_comb begin
    int k;
    logic [IW-1:0]  tgt;
    logic           hit;
    logic [FCW-1:0] cnt;
    busy_d = busy_q; opa_v_d = opa_v_q; opb_v_d = opb_v_q; rd_d = rd_q; wr_d = wr_q;
    opa_d = opa_q; opb_d = opb_q; dest_d = dest_q; rob_d = rob_q;
    pc_d = pc_q; off_d = off_q; op_d = op_q;
    k = 0; tgt = '0; hit = 1'b0; cnt = '0;
    for (int w = 0; w < WAYS; w++)
      if (iss_v[w] && fu_ready[w]) busy_d[iss_idx[w]] = 1'b0;
    // Wakeup walks ways high-to-low so the lowest matching way is the last writer.
    for (int e = 0; e < RS_SIZE; e++) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (busy_q[e] && !opa_v_q[e] && cdb_valid[w] && cdb_tag[w] == opa_q[e][TW-1:0]) begin
          opa_d[e] = cdb_data[w]; opa_v_d[e] = 1'b1;
        end
        if (busy_q[e] && !opb_v_q[e] && cdb_valid[w] && cdb_tag[w] == opb_q[e][TW-1:0]) begin
          opb_d[e] = cdb_data[w]; opb_v_d[e] = 1'b1;
        end
      end
    end
    if (squash) begin
      busy_d = '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        tgt = '0; hit = 1'b0;
        if (disp_valid[w]) begin
          for (int j = 0; j < WAYS; j++)
            if (j == k && fr_ok[j]) begin tgt = fr_idx[j]; hit = 1'b1; end
          k++;
        end
        if (hit) begin
          busy_d[tgt] = 1'b1;
          opa_d[tgt] = disp_opa[w]; opa_v_d[tgt] = disp_opa_valid[w];
          opb_d[tgt] = disp_opb[w]; opb_v_d[tgt] = disp_opb_valid[w];
          dest_d[tgt] = disp_dest_prf[w]; rob_d[tgt] = disp_rob_idx[w];
          pc_d[tgt] = disp_pc[w]; off_d[tgt] = disp_offset[w]; op_d[tgt] = disp_op[w];
          rd_d[tgt] = disp_rd_mem[w]; wr_d[tgt] = disp_wr_mem[w];
`ifdef RS_DISPATCH_BYPASS_EN
          for (int c = WAYS - 1; c >= 0; c--) begin
            if (!disp_opa_valid[w] && cdb_valid[c] && cdb_tag[c] == disp_opa[w][TW-1:0]) begin
              opa_d[tgt] = cdb_data[c]; opa_v_d[tgt] = 1'b1;
            end
            if (!disp_opb_valid[w] && cdb_valid[c] && cdb_tag[c] == disp_opb[w][TW-1:0]) begin
              opb_d[tgt] = cdb_data[c]; opb_v_d[tgt] = 1'b1;
            end
          end
`endif
        end
      end
    end
    for (int e = 0; e < RS_SIZE; e++) cnt = cnt + FCW'(busy_d[e]);
    free_count_d = FCW'(RS_SIZE) - cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      opa_v_q      <= '0;
      opb_v_q      <= '0;
      free_count_q <= FCW'(RS_SIZE);
    end else begin
      busy_q       <= busy_d;
      opa_v_q      <= opa_v_d;
      opb_v_q      <= opb_v_d;
      free_count_q <= free_count_d;
    end
  end

  // Payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clock) begin
    opa_q <= opa_d; opb_q <= opb_d; dest_q <= dest_d; rob_q <= rob_d;
    pc_q <= pc_d; off_q <= off_d; op_q <= op_d; rd_q <= rd_d; wr_q <= wr_d;
  end

  always_comb begin
    issue_valid = iss_v;
    issue_opa = '0; issue_opb = '0; issue_dest_prf = '0; issue_rob_idx = '0;
    issue_pc = '0; issue_offset = '0; issue_op = '0; issue_rd_mem = '0; issue_wr_mem = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (iss_v[w]) begin
        issue_opa[w]      = opa_q[iss_idx[w]];
        issue_opb[w]      = opb_q[iss_idx[w]];
        issue_dest_prf[w] = dest_q[iss_idx[w]];
        issue_rob_idx[w]  = rob_q[iss_idx[w]];
        issue_pc[w]       = pc_q[iss_idx[w]];
        issue_offset[w]   = off_q[iss_idx[w]];
        issue_op[w]       = op_q[iss_idx[w]];
        issue_rd_mem[w]   = rd_q[iss_idx[w]];
        issue_wr_mem[w]   = wr_q[iss_idx[w]];
      end
    end
  end

endmodule
